// File: rtl/cg_memory_arbiter.sv
// Two-requester memory arbiter: independent read and write paths, each a
// small FSM with its own round-robin pointer, one transaction in flight per path.
module cg_memory_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  // requester 0
  input  logic                  s0_raddr_valid,
  output logic                  s0_raddr_ready,
  input  logic [ADDR_WIDTH-1:0] s0_raddr,
  output logic                  s0_rdata_valid,
  input  logic                  s0_rdata_ready,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  input  logic                  s0_wdata_valid,
  output logic                  s0_wdata_ready,
  input  logic                  s0_wen,
  input  logic [ADDR_WIDTH-1:0] s0_waddr,
  input  logic [DATA_WIDTH-1:0] s0_wdata,
  // requester 1
  input  logic                  s1_raddr_valid,
  output logic                  s1_raddr_ready,
  input  logic [ADDR_WIDTH-1:0] s1_raddr,
  output logic                  s1_rdata_valid,
  input  logic                  s1_rdata_ready,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  input  logic                  s1_wdata_valid,
  output logic                  s1_wdata_ready,
  input  logic                  s1_wen,
  input  logic [ADDR_WIDTH-1:0] s1_waddr,
  input  logic [DATA_WIDTH-1:0] s1_wdata,
  // memory side
  output logic                  m_raddr_valid,
  input  logic                  m_raddr_ready,
  output logic [ADDR_WIDTH-1:0] m_raddr,
  input  logic                  m_rdata_valid,
  output logic                  m_rdata_ready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  m_wdata_valid,
  input  logic                  m_wdata_ready,
  output logic                  m_wen,
  output logic [ADDR_WIDTH-1:0] m_waddr,
  output logic [DATA_WIDTH-1:0] m_wdata
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
  typedef enum logic       {W_IDLE, W_BUSY}         wr_state_e;

  rd_state_e             r_rd_state;
  rd_state_e             w_rd_state_next;
  logic                  r_rd_ptr;    // 1 = requester 1 favoured on a tie
  logic                  r_rd_owner;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic                  w_rd_gnt0;
  logic                  w_rd_gnt1;
  logic                  w_rd_take;
  logic                  w_m_rdata_ready;

  wr_state_e             r_wr_state;
  wr_state_e             w_wr_state_next;
  logic                  r_wr_ptr;
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  w_wr_gnt0;
  logic                  w_wr_gnt1;
  logic                  w_wr_take;

  // Read data is broadcast; only the valid strobe is steered to the owner.
  assign s0_rdata      = m_rdata;
  assign s1_rdata      = m_rdata;
  assign m_raddr       = r_raddr;
  assign m_rdata_ready = w_m_rdata_ready;

  assign w_rd_gnt0 = s0_raddr_valid & (~s1_raddr_valid | ~r_rd_ptr);
  assign w_rd_gnt1 = s1_raddr_valid & (~s0_raddr_valid |  r_rd_ptr);
  assign w_rd_take = (r_rd_state == R_IDLE) & (w_rd_gnt0 | w_rd_gnt1);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_rd_state <= R_IDLE;
      r_rd_ptr   <= 1'b0;
      r_rd_owner <= 1'b0;
      r_raddr    <= '0;
    end else begin
      r_rd_state <= w_rd_state_next;
      if (w_rd_take) begin
        r_rd_ptr   <= w_rd_gnt0;
        r_rd_owner <= w_rd_gnt1;
        r_raddr    <= w_rd_gnt1 ? s1_raddr : s0_raddr;
      end
    end
  end

  always_comb begin
    w_rd_state_next = r_rd_state;
    s0_raddr_ready  = 1'b0;
    s1_raddr_ready  = 1'b0;
    s0_rdata_valid  = 1'b0;
    s1_rdata_valid  = 1'b0;
    w_m_rdata_ready = 1'b0;
    m_raddr_valid   = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        // Readies are held low while reset is asserted: a grant cannot be captured then.
        s0_raddr_ready = i_rstn & w_rd_gnt0;
        s1_raddr_ready = i_rstn & w_rd_gnt1;
        if (w_rd_take) w_rd_state_next = R_ADDR;
      end
      R_ADDR: begin
        m_raddr_valid = 1'b1;
        if (m_raddr_ready) w_rd_state_next = R_DATA;
      end
      R_DATA: begin
        if (r_rd_owner) begin
          s1_rdata_valid  = m_rdata_valid;
          w_m_rdata_ready = s1_rdata_ready;
        end else begin
          s0_rdata_valid  = m_rdata_valid;
          w_m_rdata_ready = s0_rdata_ready;
        end
        if (m_rdata_valid & w_m_rdata_ready) w_rd_state_next = R_IDLE;
      end
      default: w_rd_state_next = R_IDLE;
    endcase
  end

  assign m_wdata_valid = (r_wr_state == W_BUSY);
  assign m_wen         = r_wen;
  assign m_waddr       = r_waddr;
  assign m_wdata       = r_wdata;

  assign w_wr_gnt0 = s0_wdata_valid & (~s1_wdata_valid | ~r_wr_ptr);
  assign w_wr_gnt1 = s1_wdata_valid & (~s0_wdata_valid |  r_wr_ptr);
  assign w_wr_take = (r_wr_state == W_IDLE) & (w_wr_gnt0 | w_wr_gnt1);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_wr_state <= W_IDLE;
      r_wr_ptr   <= 1'b0;
      r_wen      <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_wr_state <= w_wr_state_next;
      if (w_wr_take) begin
        r_wr_ptr <= w_wr_gnt0;
        r_wen    <= w_wr_gnt1 ? s1_wen   : s0_wen;
        r_waddr  <= w_wr_gnt1 ? s1_waddr : s0_waddr;
        r_wdata  <= w_wr_gnt1 ? s1_wdata : s0_wdata;
      end
    end
  end

  always_comb begin
    w_wr_state_next = r_wr_state;
    s0_wdata_ready  = 1'b0;
    s1_wdata_ready  = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        s0_wdata_ready = i_rstn & w_wr_gnt0;
        s1_wdata_ready = i_rstn & w_wr_gnt1;
        if (w_wr_take) w_wr_state_next = W_BUSY;
      end
      W_BUSY: begin
        if (m_wdata_ready) w_wr_state_next = W_IDLE;
      end
      default: w_wr_state_next = W_IDLE;
    endcase
  end

endmodule
